uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 9600, line rate in bit/s.
REQ-003 SHALL provide parameter DATA_BITS, default 8, word width, legal range 5..9.
REQ-004 SHALL provide parameter PARITY, default 2, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL provide parameter STOP_BITS, default 1, stop bit count, legal values 1 or 2.
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, receive buffer entries, power of two, minimum 2.
REQ-007 SHALL provide port CLK50MHz, input, 1, the single clock for all logic.
REQ-008 SHALL provide port RESET, input, 1, asynchronous active-low reset.
REQ-009 SHALL provide port RX, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL provide port DATA, output, DATA_BITS, head-of-FIFO word, bit 0 first received.
REQ-011 SHALL provide port VALID, output, 1, FIFO non-empty.
REQ-012 SHALL provide port READY, input, 1, consumer accepts head word.
REQ-013 SHALL provide port PARITY_ERR, output, 1, parity error flag of head word.
REQ-014 SHALL provide port FRAME_ERR, output, 1, stop-bit error flag of head word.
REQ-015 SHALL provide port OVERRUN, output, 1, sticky word-dropped flag.

Function
REQ-016 SHALL synchronise RX through two flops, both initialised to 1.
REQ-017 SHALL generate a one-cycle sample enable at 16x BAUD: divisor DIV = round(CLK_HZ/(16*BAUD)), counter 0..DIV-1; no derived clocks.
REQ-018 SHALL implement the state machine IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; PARITY skipped when PARITY=0.
REQ-019 SHALL leave IDLE for START on the first enable with synchronised RX=0, resetting the 0..15 tick counter.
REQ-020 SHALL sample each bit at ticks 7, 8, 9 and use the 2-of-3 majority.
REQ-021 SHALL return from START to IDLE without pushing when the start-bit majority is 1 (glitch rejection).
REQ-022 SHALL shift DATA_BITS bits LSB first, advancing bit index at tick 15.
REQ-023 SHALL flag parity error when the XOR of data and parity bit is 1 (even) or 0 (odd).
REQ-024 SHALL flag frame error when any stop-bit majority is 0.
REQ-025 SHALL push {word, parity error, frame error} at tick 9 of the last stop bit, then go to IDLE, or to WAIT_IDLE if frame error.
REQ-026 SHALL hold WAIT_IDLE until synchronised RX=1 (break handling), then go to IDLE.
REQ-027 SHALL present the FIFO first-word-fall-through: VALID, DATA and flags reflect the head one clock after a push into an empty FIFO.
REQ-028 SHALL pop on any clock with VALID=1 and READY=1.
REQ-029 SHALL, on push into a full FIFO with no simultaneous pop, drop the new word and set OVERRUN.
REQ-030 SHALL perform both operations on simultaneous push and pop when full, without setting OVERRUN.
REQ-031 SHALL clear OVERRUN on the next pop.
REQ-032 SHALL drive DATA and flags to 0 while VALID=0.

Reset
REQ-033 SHALL, on RESET=0, immediately set state IDLE, counters 0, FIFO empty, synchroniser 1, and all outputs 0.
REQ-034 SHALL discard any partial frame on reset and resume with start detection after release.

Structure
REQ-035 SHALL place the parity-mode constants, state enumeration and divisor function in shared package uart_pkg.
REQ-036 SHALL implement the buffer as sub-module uart_rx_fifo (synchronous, parametrised width and depth); tick generator and FSM stay inline.

Verification
REQ-037 SHALL cover: defaults, frame 0xA5 with parity 0 -> DATA=0xA5, VALID=1, PARITY_ERR=0, FRAME_ERR=0.
REQ-038 SHALL cover: 0x01 with parity bit 0 (even) -> DATA=0x01, PARITY_ERR=1.
REQ-039 SHALL cover: stop bit held 0 for 3 bit times -> FRAME_ERR=1; no second word until RX returns high.
REQ-040 SHALL cover: RX low for 4 sample ticks only -> no push, VALID stays 0.
REQ-041 SHALL cover: READY=0, five words 0x11..0x55 -> FIFO holds 0x11..0x44, OVERRUN=1; one pop -> OVERRUN=0, DATA=0x22.
REQ-042 SHALL cover: PARITY=0, DATA_BITS=7, STOP_BITS=2, RESET pulsed mid-frame then word 0x3C -> only 0x3C received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and helper functions for the configurable UART receiver.
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Rounded clock divider for the 16x oversampling enable; never below 1.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + 32'sd8 * baud) / (32'sd16 * baud);
    if (d < 32'sd1) begin
      d = 32'sd1;
    end else begin
      d = d;
    end
    return d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side word stream: head word plus its error flags, with a consumer ready.
interface uart_rx_cfg_if #(parameter int DW = 8);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          perr;
  logic          ferr;

  modport master (output valid, data, perr, ferr, input ready);
  modport slave  (input valid, data, perr, ferr, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer with a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_perr,
  input  logic          push_ferr,
  uart_rx_cfg_if.master rd,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [DW+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          full_s, pop_s, wr_en_s;
  logic [DW+1:0] head_s;

  // When full, a simultaneous pop frees the slot the new word lands in.
  always_comb begin
    full_s  = (cnt_q == (AW+1)'(DEPTH));
    pop_s   = (cnt_q != '0) && rd.ready;
    wr_en_s = push && (!full_s || pop_s);
    wr_d    = wr_en_s ? wr_q + AW'(1) : wr_q;
    rd_d    = pop_s ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
    if (pop_s) begin
      ovr_d = 1'b0;
    end else if (push && full_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_q] <= {push_data, push_perr, push_ferr};
    end
  end

  assign head_s  = mem_q[rd_q];
  assign overrun = ovr_q;

  always_comb begin
    if (cnt_q != '0) begin
      rd.valid = 1'b1;
      rd.data  = head_s[DW+1:2];
      rd.perr  = head_s[1];
      rd.ferr  = head_s[0];
    end else begin
      rd.valid = 1'b0;
      rd.data  = '0;
      rd.perr  = 1'b0;
      rd.ferr  = 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 2-of-3 bit voting, optional parity,
// 1 or 2 stop bits, break handling and a small FWFT receive buffer.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK50MHz,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN
);

  localparam int            DIV       = calc_div(CLK_HZ, BAUD);
  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  logic [CW-1:0]        div_q, div_d;
  logic                 en_q, en_d;
  rx_state_e            state_q, state_d;
  logic [3:0]           tick_q, tick_d, bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, word_q, word_d;
  logic                 s7_q, s7_d, s8_q, s8_d, par_q, par_d, ferr_q, ferr_d;
  logic                 push_q, push_d, pe_q, pe_d, fe_q, fe_d;
  logic                 mid_s, last_s, maj_s, ferr_s, xor_s, perr_s;

  always_comb begin
    en_d  = (div_q == DIV_LAST);
    div_d = en_d ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      div_q     <= '0;
      en_q      <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      div_q     <= div_d;
      en_q      <= en_d;
    end
  end

  // Tick 9 holds the third vote; samples from ticks 7 and 8 are already registered.
  always_comb begin
    mid_s  = (tick_q == 4'd9);
    last_s = (tick_q == 4'd15);
    maj_s  = maj3(s7_q, s8_q, rx_sync_q);
    ferr_s = ferr_q | ~maj_s;
    xor_s  = ^{shift_q, par_q};
    if (PARITY == PAR_EVEN) begin
      perr_s = xor_s;
    end else if (PARITY == PAR_ODD) begin
      perr_s = ~xor_s;
    end else begin
      perr_s = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;
    word_d  = word_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    if (en_q) begin
      tick_d = tick_q + 4'd1;
      s7_d   = (tick_q == 4'd7) ? rx_sync_q : s7_q;
      s8_d   = (tick_q == 4'd8) ? rx_sync_q : s8_q;
      case (state_q)
        ST_IDLE: begin
          tick_d = 4'd0;
          if (!rx_sync_q) begin
            state_d = ST_START;
            ferr_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s && maj_s) begin
            state_d = ST_IDLE;
            tick_d  = 4'd0;
          end else if (last_s) begin
            state_d = ST_DATA;
            bit_d   = 4'd0;
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          shift_d = mid_s ? {maj_s, shift_q[DATA_BITS-1:1]} : shift_q;
          if (last_s && (bit_q == BIT_LAST)) begin
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            bit_d   = 4'd0;
          end else if (last_s) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = bit_q;
          end
        end
        ST_PARITY: begin
          par_d   = mid_s ? maj_s : par_q;
          state_d = last_s ? ST_STOP : ST_PARITY;
        end
        ST_STOP: begin
          if (mid_s && (bit_q == STOP_LAST)) begin
            ferr_d  = ferr_s;
            push_d  = 1'b1;
            word_d  = shift_q;
            pe_d    = perr_s;
            fe_d    = ferr_s;
            state_d = ferr_s ? ST_WAIT_IDLE : ST_IDLE;
            tick_d  = 4'd0;
          end else if (mid_s) begin
            ferr_d = ferr_s;
          end else if (last_s) begin
            bit_d = bit_q + 4'd1;
          end else begin
            bit_d = bit_q;
          end
        end
        ST_WAIT_IDLE: begin
          tick_d  = 4'd0;
          state_d = rx_sync_q ? ST_IDLE : ST_WAIT_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 4'd0;
      shift_q <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      word_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
      word_q  <= word_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  uart_rx_cfg_if #(.DW(DATA_BITS)) rd_if ();

  uart_rx_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK50MHz),
    .rst_n     (RESET),
    .push      (push_q),
    .push_data (word_q),
    .push_perr (pe_q),
    .push_ferr (fe_q),
    .rd        (rd_if),
    .overrun   (OVERRUN)
  );

  assign rd_if.ready = READY;
  assign DATA        = rd_if.data;
  assign VALID       = rd_if.valid;
  assign PARITY_ERR  = rd_if.perr;
  assign FRAME_ERR   = rd_if.ferr;

endmodule
